// File: rtl/mult_div_if.sv
// Operand/result bundle between the control datapath and the multiply/divide unit.
// The master drives the operands and the op code; the slave returns results and status.
interface mult_div_if;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  op;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  modport master (output a, b, op, input hi, lo, busy, done, div_zero);
  modport slave  (input a, b, op, output hi, lo, busy, done, div_zero);
endinterface

// File: rtl/mult_div_seq.sv
// Sequential 32x32 signed multiply (radix-2 Booth) and signed divide (restoring on
// magnitudes), 32 iterations each, with a one-cycle done pulse and divide-by-zero flag.
module mult_div_seq (
  input  logic        clk,
  input  logic        reset,
  mult_div_if.slave   bus
);
  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_FINISH} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  // MULT: {P[63:0], q-1}; DIV: {unused, rem[31:0], quo[31:0]}
  logic [64:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        is_div_q, is_div_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        div_zero_q, div_zero_d;

  logic        accept;
  logic [32:0] p_ext, m_ext, booth_sum;
  logic [63:0] shifted;
  logic [32:0] trial;
  logic [31:0] a_abs, b_abs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    accept     = 1'b0;
    p_ext      = {acc_q[64], acc_q[64:33]};
    m_ext      = {opnd_q[31], opnd_q};
    booth_sum  = p_ext;
    shifted    = {acc_q[62:0], 1'b0};
    trial      = {1'b0, shifted[63:32]} - {1'b0, opnd_q};
    a_abs      = bus.a[31] ? (32'd0 - bus.a) : bus.a;
    b_abs      = bus.b[31] ? (32'd0 - bus.b) : bus.b;

    case (state_q)
      S_MULT: begin
        case (acc_q[1:0])
          2'b01:   booth_sum = p_ext + m_ext;
          2'b10:   booth_sum = p_ext - m_ext;
          default: booth_sum = p_ext;
        endcase
        // 33-bit sum keeps the sign when subtracting the most negative multiplicand
        acc_d = {booth_sum, acc_q[32:1]};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = S_FINISH;
      end
      S_DIV: begin
        if (!trial[32]) acc_d = {1'b0, trial[31:0], shifted[31:1], 1'b1};
        else            acc_d = {1'b0, shifted};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = S_FINISH;
      end
      S_FINISH: begin
        if (is_div_q) begin
          lo_d = neg_quo_q ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
          hi_d = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
        end else begin
          hi_d = acc_q[64:33];
          lo_d = acc_q[32:1];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
        accept  = 1'b1;
      end
      default: accept = 1'b1;
    endcase

    // Start decode also runs in FINISH so back-to-back operations lose no cycle
    if (accept) begin
      case (bus.op)
        2'b01: begin
          div_zero_d = 1'b0;
          is_div_d   = 1'b0;
          opnd_d     = bus.a;
          acc_d      = {32'd0, bus.b, 1'b0};
          cnt_d      = 5'd31;
          state_d    = S_MULT;
        end
        2'b10: begin
          if (bus.b == 32'd0) begin
            div_zero_d = 1'b1;
            done_d     = 1'b1;
          end else begin
            div_zero_d = 1'b0;
            is_div_d   = 1'b1;
            neg_quo_d  = bus.a[31] ^ bus.b[31];
            neg_rem_d  = bus.a[31];
            opnd_d     = b_abs;
            acc_d      = {33'd0, a_abs};
            cnt_d      = 5'd31;
            state_d    = S_DIV;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
endmodule

// File: tb/tb_mult_div_seq.sv
// Directed self-checking bench for mult_div_seq: signed MULT/DIV results, latency,
// divide-by-zero, op-ignored-while-busy and asynchronous reset mid-operation.
module tb_mult_div_seq;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  mult_div_if bus ();

  mult_div_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Issue one start and follow it to its done pulse, checking latency and busy length.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int lat;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    bus.op = o;
    bus.a  = av;
    bus.b  = bv;
    @(posedge clk);
    #1;
    bus.op   = 2'b00;
    busy_cnt = int'(bus.busy);
    lat      = 0;
    seen     = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        seen = 1'b1;
        lat  = i;
        check_val({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
      end else begin
        busy_cnt += int'(bus.busy);
      end
    end
    check_val({tag, " latency"}, 64'(lat), 64'd33);
    check_val({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
    check_val({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
    check_val({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
  endtask

  initial begin
    int done_cnt;
    int first_done;
    n_checks = 0;
    n_errors = 0;
    reset  = 1'b1;
    bus.op = 2'b00;
    bus.a  = '0;
    bus.b  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset hi", 64'(bus.hi), 64'd0);
    check_val("reset lo", 64'(bus.lo), 64'd0);
    check_val("reset busy", 64'(bus.busy), 64'd0);
    check_val("reset done", 64'(bus.done), 64'd0);
    check_val("reset div_zero", 64'(bus.div_zero), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("mult 7*-3", 2'b01, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("mult min*min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("mult -1*-1", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1);
    run_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD);
    run_op("div min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    check_val("div overflow no flag", 64'(bus.div_zero), 64'd0);
    run_op("div 95/10", 2'b10, 32'd95, 32'd10, 32'd5, 32'd9);

    // Divide by zero: immediate done, sticky flag, results held
    @(negedge clk);
    bus.op = 2'b10;
    bus.a  = 32'd123;
    bus.b  = 32'd0;
    @(posedge clk);
    #1;
    bus.op = 2'b00;
    check_val("dz done", 64'(bus.done), 64'd1);
    check_val("dz flag", 64'(bus.div_zero), 64'd1);
    check_val("dz busy", 64'(bus.busy), 64'd0);
    check_val("dz hi held", 64'(bus.hi), 64'd5);
    check_val("dz lo held", 64'(bus.lo), 64'd9);
    @(posedge clk);
    #1;
    check_val("dz done fall", 64'(bus.done), 64'd0);
    check_val("dz flag sticky", 64'(bus.div_zero), 64'd1);
    run_op("mult 2*21", 2'b01, 32'd2, 32'd21, 32'd0, 32'd42);
    check_val("dz cleared by mult", 64'(bus.div_zero), 64'd0);

    // op and operand changes while busy are ignored
    @(negedge clk);
    bus.op = 2'b01;
    bus.a  = 32'd6;
    bus.b  = 32'd7;
    @(posedge clk);
    #1;
    bus.op = 2'b00;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.op = 2'b10;
    bus.b  = 32'd3;
    @(posedge clk);
    #1;
    bus.op = 2'b00;
    @(negedge clk);
    bus.a = 32'd100;
    bus.b = 32'd100;
    done_cnt   = 0;
    first_done = 0;
    for (int i = 6; i <= 45; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        done_cnt++;
        if (first_done == 0) first_done = i;
      end
    end
    check_val("ignore done count", 64'(done_cnt), 64'd1);
    check_val("ignore done edge", 64'(first_done), 64'd33);
    check_val("ignore hi", 64'(bus.hi), 64'd0);
    check_val("ignore lo", 64'(bus.lo), 64'd42);
    check_val("ignore div_zero", 64'(bus.div_zero), 64'd0);

    // Asynchronous reset in the middle of a DIV
    @(negedge clk);
    bus.op = 2'b10;
    bus.a  = 32'd1000;
    bus.b  = 32'd7;
    @(posedge clk);
    #1;
    bus.op = 2'b00;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_val("arst hi", 64'(bus.hi), 64'd0);
    check_val("arst lo", 64'(bus.lo), 64'd0);
    check_val("arst busy", 64'(bus.busy), 64'd0);
    check_val("arst done", 64'(bus.done), 64'd0);
    check_val("arst div_zero", 64'(bus.div_zero), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op("mult 3*4", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
